// File: rtl/alu_pkg.sv
// ALU control codes shared with the ALU control decoder, plus EX-stage FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_CMP  = 4'b0100;
  localparam logic [3:0] ALU_BEQ  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SLR  = 4'b1101;
  localparam logic [3:0] ALU_SLLV = 4'b1110;
  localparam logic [3:0] ALU_SLRV = 4'b1111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // All four shift codes share the 11xx prefix; bit 1 selects the variable
  // amount, bit 0 selects a right shift.
  function automatic logic is_shift_op(input logic [3:0] code);
    return code[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: shift register plus down counter of bits left.
module alu_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               dir,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amt,
  output logic [WIDTH-1:0]   next_data,
  output logic               last
);

  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] count;
  logic               dir_q;

  // Value after the next shift step; the top captures it on the final step
  // so the visible result jumps straight to the finished value.
  assign next_data = dir_q ? (data >> 1) : (data << 1);
  assign last      = (count == SHAMT_W'(1));

  // Load operand/amount/direction, then step once per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      data  <= din;
      count <= amt;
      dir_q <= dir;
    end else if (en) begin
      data  <= next_data;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arithmetic, serial shifts, registered result/flags.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               negative,
  output logic               carry,
  output logic               overflow,
  output logic               illegal
);

  state_t             state_q, state_d;
  logic               accept, shift_op, shift_go, sh_last;
  logic [SHAMT_W-1:0] sh_amt;
  logic [WIDTH-1:0]   sh_next;
  logic [WIDTH:0]     sum, diff;
  logic               ovf_add, ovf_sub, lt;
  logic [WIDTH-1:0]   res_c;
  logic               z_c, n_c, c_c, v_c, ill_c;

  assign busy     = (state_q == ST_SHIFT);
  assign accept   = start && !busy;
  assign shift_op = is_shift_op(alu_ctrl);
  assign sh_amt   = alu_ctrl[1] ? b[SHAMT_W-1:0] : shamt;
  // Zero-length shifts complete like single-cycle ops and never enter SHIFT.
  assign shift_go = accept && shift_op && (sh_amt != '0);

  // diff carries not-borrow in its top bit (a + ~b + 1).
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign lt      = $signed(a) < $signed(b);

  // Single-cycle result and flags; CMP reports the flags of a-b, not of its 0/1 result.
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    ill_c = 1'b0;
    case (alu_ctrl)
      ALU_AND: res_c = a & b;
      ALU_ADD: begin res_c = sum[WIDTH-1:0];  c_c = sum[WIDTH];  v_c = ovf_add; end
      ALU_SUB,
      ALU_BEQ: begin res_c = diff[WIDTH-1:0]; c_c = diff[WIDTH]; v_c = ovf_sub; end
      ALU_CMP: begin res_c = {{(WIDTH-1){1'b0}}, lt}; c_c = diff[WIDTH]; v_c = ovf_sub; end
      ALU_SLL, ALU_SLR, ALU_SLLV, ALU_SLRV: res_c = a;
      default: ill_c = 1'b1;
    endcase
    z_c = (res_c == '0);
    n_c = res_c[WIDTH-1];
    if (alu_ctrl == ALU_CMP) begin
      z_c = (diff[WIDTH-1:0] == '0);
      n_c = diff[WIDTH-1];
    end
    if (ill_c) begin
      z_c = 1'b0;
      n_c = 1'b0;
    end
  end

  alu_serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift_go),
    .en        (busy),
    .dir       (alu_ctrl[0]),
    .din       (a),
    .amt       (sh_amt),
    .next_data (sh_next),
    .last      (sh_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: enter SHIFT on a non-zero shift, leave on the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (shift_go) state_d = ST_SHIFT;
      ST_SHIFT: if (sh_last)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output registers change only on completion; done pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && sh_last) begin
        done     <= 1'b1;
        result   <= sh_next;
        zero     <= (sh_next == '0);
        negative <= sh_next[WIDTH-1];
        carry    <= 1'b0;
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end else if (accept && !shift_go) begin
        done     <= 1'b1;
        result   <= res_c;
        zero     <= z_c;
        negative <= n_c;
        carry    <= c_c;
        overflow <= v_c;
        illegal  <= ill_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued at issue, checked on done.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero, negative, carry, overflow, illegal;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];   // {result, zero, negative, carry, overflow, illegal}

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference behaviour written from the op definitions with wide signed math.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sa);
    logic [31:0] r;
    logic z, ng, c, v, il;
    logic [32:0] s, d;
    longint ss, sd;
    int n;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    s  = {1'b0, x} + {1'b0, y};
    d  = {1'b0, x} - {1'b0, y};
    ss = longint'($signed(x)) + longint'($signed(y));
    sd = longint'($signed(x)) - longint'($signed(y));
    n  = op[1] ? int'(y[4:0]) : int'(sa);
    case (op)
      ALU_AND: r = x & y;
      ALU_ADD: begin r = s[31:0]; c = s[32]; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
      ALU_SUB, ALU_BEQ, ALU_CMP: begin
        r = d[31:0]; c = (x >= y); v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        if (op == ALU_CMP) r = {31'b0, ($signed(x) < $signed(y))};
      end
      ALU_SLL, ALU_SLLV: r = x << n;
      ALU_SLR, ALU_SLRV: r = x >> n;
      default: il = 1'b1;
    endcase
    z = (r == 0); ng = r[31];
    if (op == ALU_CMP) begin z = (x == y); ng = d[31]; end
    if (il) begin z = 1'b0; ng = 1'b0; end
    return {r, z, ng, c, v, il};
  endfunction

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else chk("result_flags", {27'b0, result, zero, negative, carry, overflow, illegal},
               {27'b0, exp_q.pop_front()});
    end
  end

  // Issue one op (called right after a negedge) and wait for its done.
  task automatic run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] sa, input logic [36:0] e);
    int lat, bcnt, n, exp_lat;
    n = op[1] ? int'(y[4:0]) : int'(sa);
    exp_lat = (is_shift_op(op) && n != 0) ? n + 1 : 1;
    alu_ctrl = op; a = x; b = y; shamt = sa; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk); lat++;
      if (busy) bcnt++;
    end while (!done && lat < 100);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(bcnt), 64'(exp_lat - 1));
  endtask

  logic [3:0] ops[11] = '{ALU_AND, ALU_ADD, ALU_SUB, ALU_CMP, ALU_BEQ, ALU_SLL,
                          ALU_SLR, ALU_SLLV, ALU_SLRV, 4'b0000, 4'b1000};

  initial begin
    int lat;
    logic [3:0] op;
    logic [31:0] x, y;
    logic [4:0] sa;

    #12;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", {59'b0, zero, negative, carry, overflow, illegal}, 64'd0);
    chk("rst_busy_done", {62'b0, busy, done}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run(ALU_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, {32'h80000000, 5'b01010});
    run(ALU_SUB, 32'd5, 32'd5, 5'd0, {32'h0, 5'b10100});
    run(ALU_BEQ, 32'd5, 32'd5, 5'd0, {32'h0, 5'b10100});
    run(ALU_CMP, 32'hFFFFFFFF, 32'd1, 5'd0, {32'h1, 5'b01100});
    run(ALU_SLLV, 32'h1, 32'd31, 5'd0, {32'h80000000, 5'b01000});
    run(ALU_SLR, 32'h80000000, 32'd0, 5'd0, {32'h80000000, 5'b01000});
    run(4'b0000, 32'hFFFF, 32'h1, 5'd3, {32'h0, 5'b00001});
    run(ALU_AND, 32'hF0, 32'h3C, 5'd0, {32'h30, 5'b00000});

    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 10)];
      x  = $urandom; y = $urandom; sa = 5'($urandom_range(0, 31));
      if (i % 3 == 0) y[31] = x[31];
      run(op, x, y, sa, model(op, x, y, sa));
    end

    // SLL by 8 with start pulses while busy: they must be dropped.
    alu_ctrl = ALU_SLL; a = 32'h12345678; shamt = 5'd8; start = 1'b1;
    exp_q.push_back({32'h34567800, 5'b00000});
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat >= 2 && lat <= 4) begin
        alu_ctrl = ALU_ADD; a = 32'h1; b = 32'h1; start = 1'b1;
      end else start = 1'b0;
    end while (!done && lat < 100);
    start = 1'b0;
    chk("ignore_latency", 64'(lat), 64'd9);
    repeat (3) @(negedge clk);
    chk("ignore_no_extra_done", 64'(done), 64'd0);

    // Reset in the middle of a shift: abort without done.
    alu_ctrl = ALU_SLL; a = 32'hFF; shamt = 5'd8; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_busy_done", {62'b0, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) lat++;
    end
    chk("post_rst_quiet", 64'(lat), 64'd0);
    chk("post_rst_result", 64'(result), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
